maquina_bebidas_multi: RTL and testbench
========================================

MAQUINA_BEBIDAS_MULTI -- requirements
Module: maquina_bebidas_multi

Interface
REQ-001 Parameter N_BEBIDAS, default 4, number of selectable drinks (2..16).
REQ-002 Parameter CREDIT_W, default 8, width of credit, price and change values.
REQ-003 Parameter DISPENSE_CYC, default 16, cycles the dispense output stays asserted (>=1).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 hm  input  1  coin present, one-cycle pulse.
REQ-007 tm  input  2  coin type: 0=1, 1=2, 2=5, 3=10 credit units.
REQ-008 ha  input  1  water available, level.
REQ-009 hc  input  N_BEBIDAS  per-drink supply available, level.
REQ-010 bp  input  1  selection button, one-cycle pulse.
REQ-011 bb  input  clog2(N_BEBIDAS)  selected drink index, sampled with bp.
REQ-012 cancelar  input  1  cancel request, one-cycle pulse.
REQ-013 precio  input  N_BEBIDAS*CREDIT_W  flat price table, drink i in bits [i*CREDIT_W +: CREDIT_W].
REQ-014 out  output  3  state code (see REQ-019).
REQ-015 credito  output  CREDIT_W  accumulated credit.
REQ-016 sirviendo  output  1  high while dispensing.
REQ-017 cambio_valid / cambio  output  1 / CREDIT_W  one-cycle change-return pulse and amount.
REQ-018 moneda_rechazo  output  1  one-cycle pulse, coin returned unaccepted.

Function
REQ-019 States and out codes: REPOSO 000, CREDITO 001, VALIDAR 010, SERVIR 011, CAMBIO 100, DEVOLVER 101.
REQ-020 REPOSO/CREDITO + hm: credit += coin value, visible next cycle; state -> CREDITO.
REQ-021 Coin whose addition exceeds 2^CREDIT_W-1: not added, moneda_rechazo pulses next cycle.
REQ-022 hm in VALIDAR, SERVIR, CAMBIO or DEVOLVER: rejected via moneda_rechazo.
REQ-023 CREDITO + bp: latch bb, -> VALIDAR; bp in REPOSO ignored.
REQ-024 VALIDAR (one cycle): bb<N_BEBIDAS and ha and hc[bb] and credito>=precio[bb] -> SERVIR.
REQ-025 VALIDAR with only credit insufficient (or bb out of range) -> CREDITO, credit unchanged.
REQ-026 VALIDAR with ha=0 or hc[bb]=0 -> DEVOLVER.
REQ-027 SERVIR: sirviendo=1 exactly DISPENSE_CYC cycles; on exit credit -= precio[bb].
REQ-028 After SERVIR: remainder >0 -> CAMBIO, else -> REPOSO.
REQ-029 CAMBIO and DEVOLVER each last one cycle: cambio_valid=1, cambio=credito, credit cleared, -> REPOSO.
REQ-030 CREDITO + cancelar -> DEVOLVER; cancelar in other states ignored.
REQ-031 Simultaneous events in CREDITO, priority cancelar > hm > bp; lower-priority pulses dropped; hm dropped by cancelar is reported via moneda_rechazo.
REQ-032 ha/hc changes during SERVIR do not abort dispensing.

Reset
REQ-033 rst asserted: state REPOSO, out=000, credito=0, sirviendo=0, cambio_valid=0, cambio=0, moneda_rechazo=0, dispense counter 0.
REQ-034 Reset mid-operation (including SERVIR) discards credit; no change pulse issued.
REQ-035 First state change possible on first rising clk edge after rst deasserts.

Structure
REQ-036 Package maquina_pkg holds state enum with codes of REQ-019 and coin-value constants.
REQ-037 Sub-module temporizador_servicio: loadable down counter generating sirviendo and done.
REQ-038 Credit arithmetic CREDIT_W+1 bits internally for overflow detection; no other wider storage.

Verification (N_BEBIDAS=4, CREDIT_W=8, DISPENSE_CYC=4, precio={5,7,10,12})
REQ-039 Coins 5,5 (tm=2 twice), bp bb=2, ha=1, hc=1111 -> credito 10, SERVIR 4 cycles, REPOSO, no cambio_valid.
REQ-040 Coins 10,2, bp bb=1 -> SERVIR 4 cycles, CAMBIO cambio=5, credito=0.
REQ-041 Coin 5, bp bb=3 -> VALIDAR then CREDITO, credito stays 5; cancelar -> DEVOLVER cambio=5.
REQ-042 Coin 10, hc=1011, bp bb=2 -> DEVOLVER cambio=10, out 101 then 000.
REQ-043 Credit 250, coin 10 -> moneda_rechazo, credito 250; hm+cancelar same cycle -> DEVOLVER cambio=250, moneda_rechazo.
REQ-044 rst asserted during SERVIR cycle 2 -> all outputs zero immediately, no cambio_valid afterwards.

Source files
------------

// File: rtl/maquina_pkg.sv
// Shared definitions for the multi-drink vending machine.
//   estado_t      : controller states; the encoding is the externally visible
//                   'out' state code.
//   MONEDA_*      : credit value of each coin type.
//   valor_moneda  : maps the 2-bit coin type to its credit value.
package maquina_pkg;

  typedef enum logic [2:0] {
    REPOSO   = 3'b000,
    CREDITO  = 3'b001,
    VALIDAR  = 3'b010,
    SERVIR   = 3'b011,
    CAMBIO   = 3'b100,
    DEVOLVER = 3'b101
  } estado_t;

  localparam logic [3:0] MONEDA_1  = 4'd1;
  localparam logic [3:0] MONEDA_2  = 4'd2;
  localparam logic [3:0] MONEDA_5  = 4'd5;
  localparam logic [3:0] MONEDA_10 = 4'd10;

  function automatic logic [3:0] valor_moneda(input logic [1:0] tipo);
    logic [3:0] v;
    case (tipo)
      2'd0:    v = MONEDA_1;
      2'd1:    v = MONEDA_2;
      2'd2:    v = MONEDA_5;
      default: v = MONEDA_10;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/temporizador_servicio.sv
// Dispense timer: loadable down counter.
//   clk, rst  : clock, asynchronous active-high reset
//   cargar_i  : load the counter with CICLOS (start of dispensing)
//   activo_o  : high while the counter is non-zero (dispense output)
//   fin_o     : high during the last active cycle
module temporizador_servicio #(
  parameter int unsigned CICLOS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic cargar_i,
  output logic activo_o,
  output logic fin_o
);

  localparam int unsigned CNT_W = $clog2(CICLOS + 1);

  logic [CNT_W-1:0] cuenta_q, cuenta_d;

  always_comb begin
    cuenta_d = cuenta_q;
    if (cargar_i) begin
      cuenta_d = CNT_W'(CICLOS);
    end else if (cuenta_q != '0) begin
      cuenta_d = cuenta_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  assign activo_o = (cuenta_q != '0);
  assign fin_o    = (cuenta_q == CNT_W'(1));

endmodule

// File: rtl/maquina_bebidas_multi.sv
// Multi-drink vending machine controller.
//   clk, rst       : clock, asynchronous active-high reset
//   hm, tm         : coin pulse and coin type (1/2/5/10 credit units)
//   ha, hc         : water available, per-drink supply available (levels)
//   bp, bb         : selection pulse and drink index
//   cancelar       : cancel pulse (honoured only while holding credit)
//   precio         : flat price table, drink i at [i*CREDIT_W +: CREDIT_W]
//   out            : current state code
//   credito        : accumulated credit
//   sirviendo      : dispense output
//   cambio_valid   : one-cycle change pulse, amount on cambio
//   moneda_rechazo : one-cycle pulse, coin returned unaccepted
module maquina_bebidas_multi
  import maquina_pkg::*;
#(
  parameter int unsigned N_BEBIDAS    = 4,
  parameter int unsigned CREDIT_W     = 8,
  parameter int unsigned DISPENSE_CYC = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            hm,
  input  logic [1:0]                      tm,
  input  logic                            ha,
  input  logic [N_BEBIDAS-1:0]            hc,
  input  logic                            bp,
  input  logic [$clog2(N_BEBIDAS)-1:0]    bb,
  input  logic                            cancelar,
  input  logic [N_BEBIDAS*CREDIT_W-1:0]   precio,
  output logic [2:0]                      out,
  output logic [CREDIT_W-1:0]             credito,
  output logic                            sirviendo,
  output logic                            cambio_valid,
  output logic [CREDIT_W-1:0]             cambio,
  output logic                            moneda_rechazo
);

  localparam int unsigned SEL_W = $clog2(N_BEBIDAS);

  estado_t             estado_q, estado_d;
  logic [CREDIT_W-1:0] credito_q, credito_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                rechazo_q, rechazo_d;

  logic                cargar;
  logic                serv_activo;
  logic                serv_fin;

  // One extra bit so an overflowing coin is visible before it is stored.
  logic [CREDIT_W:0]   suma;
  logic                desborde;
  logic [CREDIT_W-1:0] resto;

  logic [CREDIT_W-1:0] precio_sel;
  logic                hc_sel;
  logic                sel_valida;

  assign suma     = {1'b0, credito_q} + (CREDIT_W + 1)'(valor_moneda(tm));
  assign desborde = suma[CREDIT_W];
  assign resto    = credito_q - precio_sel;

  // Decode the latched selection; an index with no matching drink leaves
  // sel_valida low, so hc/precio are never read out of range.
  always_comb begin
    precio_sel = '0;
    hc_sel     = 1'b0;
    sel_valida = 1'b0;
    for (int unsigned i = 0; i < N_BEBIDAS; i++) begin
      if (sel_q == SEL_W'(i)) begin
        precio_sel = precio[i*CREDIT_W +: CREDIT_W];
        hc_sel     = hc[i];
        sel_valida = 1'b1;
      end
    end
  end

  always_comb begin
    estado_d  = estado_q;
    credito_d = credito_q;
    sel_d     = sel_q;
    rechazo_d = 1'b0;
    cargar    = 1'b0;
    case (estado_q)
      REPOSO: begin
        if (hm) begin
          if (desborde) begin
            rechazo_d = 1'b1;
          end else begin
            credito_d = suma[CREDIT_W-1:0];
            estado_d  = CREDITO;
          end
        end
      end
      CREDITO: begin
        // cancelar > hm > bp; a coin arriving with cancel is handed back.
        if (cancelar) begin
          estado_d  = DEVOLVER;
          rechazo_d = hm;
        end else if (hm) begin
          if (desborde) begin
            rechazo_d = 1'b1;
          end else begin
            credito_d = suma[CREDIT_W-1:0];
          end
        end else if (bp) begin
          sel_d    = bb;
          estado_d = VALIDAR;
        end
      end
      VALIDAR: begin
        rechazo_d = hm;
        if (!sel_valida) begin
          estado_d = CREDITO;
        end else if (!ha || !hc_sel) begin
          estado_d = DEVOLVER;
        end else if (credito_q < precio_sel) begin
          estado_d = CREDITO;
        end else begin
          estado_d = SERVIR;
          cargar   = 1'b1;
        end
      end
      SERVIR: begin
        rechazo_d = hm;
        if (serv_fin) begin
          credito_d = resto;
          estado_d  = (resto != '0) ? CAMBIO : REPOSO;
        end
      end
      CAMBIO, DEVOLVER: begin
        rechazo_d = hm;
        credito_d = '0;
        estado_d  = REPOSO;
      end
      default: begin
        estado_d  = REPOSO;
        credito_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q  <= REPOSO;
      credito_q <= '0;
      sel_q     <= '0;
      rechazo_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      credito_q <= credito_d;
      sel_q     <= sel_d;
      rechazo_q <= rechazo_d;
    end
  end

  temporizador_servicio #(
    .CICLOS (DISPENSE_CYC)
  ) u_temporizador (
    .clk      (clk),
    .rst      (rst),
    .cargar_i (cargar),
    .activo_o (serv_activo),
    .fin_o    (serv_fin)
  );

  // Change is presented straight from the state register so that reset
  // silences it in the same instant.
  assign out            = estado_q;
  assign credito        = credito_q;
  assign sirviendo      = serv_activo;
  assign cambio_valid   = (estado_q == CAMBIO) || (estado_q == DEVOLVER);
  assign cambio         = cambio_valid ? credito_q : '0;
  assign moneda_rechazo = rechazo_q;

endmodule

// File: tb/tb_maquina_bebidas_multi.sv
// Testbench for maquina_bebidas_multi (N_BEBIDAS=4, CREDIT_W=8,
// DISPENSE_CYC=4, prices 5/7/10/12). Change and coin-return pulses are
// matched against queues of expected values filled by the scenario tasks.
module tb_maquina_bebidas_multi;

  logic        clk;
  logic        rst;
  logic        hm;
  logic [1:0]  tm;
  logic        ha;
  logic [3:0]  hc;
  logic        bp;
  logic [1:0]  bb;
  logic        cancelar;
  logic [31:0] precio;
  logic [2:0]  out;
  logic [7:0]  credito;
  logic        sirviendo;
  logic        cambio_valid;
  logic [7:0]  cambio;
  logic        moneda_rechazo;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_cambio[$];
  logic [7:0] exp_rech[$];

  maquina_bebidas_multi #(
    .N_BEBIDAS    (4),
    .CREDIT_W     (8),
    .DISPENSE_CYC (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hm             (hm),
    .tm             (tm),
    .ha             (ha),
    .hc             (hc),
    .bp             (bp),
    .bb             (bb),
    .cancelar       (cancelar),
    .precio         (precio),
    .out            (out),
    .credito        (credito),
    .sirviendo      (sirviendo),
    .cambio_valid   (cambio_valid),
    .cambio         (cambio),
    .moneda_rechazo (moneda_rechazo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard side: every output pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (cambio_valid !== 1'b0) begin
        n_cmp++;
        if (exp_cambio.size() == 0) begin
          n_err++;
          $display("FAIL cambio_unexpected: got cambio_valid=%b cambio=%0d, required no pulse", cambio_valid, cambio);
        end else begin
          logic [7:0] e;
          e = exp_cambio.pop_front();
          if (cambio !== e) begin
            n_err++;
            $display("FAIL cambio_amount: got %0d, required %0d", cambio, e);
          end
        end
      end
      if (moneda_rechazo !== 1'b0) begin
        n_cmp++;
        if (exp_rech.size() == 0) begin
          n_err++;
          $display("FAIL rechazo_unexpected: got moneda_rechazo=%b, required no pulse", moneda_rechazo);
        end else begin
          logic [7:0] e;
          e = exp_rech.pop_front();
          if (credito !== e) begin
            n_err++;
            $display("FAIL rechazo_credito: got credito=%0d at rejection, required %0d", credito, e);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic coin(input logic [1:0] t);
    hm = 1'b1; tm = t;
    cyc();
    hm = 1'b0;
  endtask

  task automatic press(input logic [1:0] b);
    bp = 1'b1; bb = b;
    cyc();
    bp = 1'b0;
  endtask

  task automatic cancel();
    cancelar = 1'b1;
    cyc();
    cancelar = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; hm = 0; tm = 0; ha = 1; hc = 4'b1111; bp = 0; bb = 0; cancelar = 0;
    precio = {8'd12, 8'd10, 8'd7, 8'd5};
    cyc(); cyc();
    n_cmp++;
    if ({out, credito, sirviendo, cambio_valid, cambio, moneda_rechazo} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got out=%b credito=%0d sirv=%b cv=%b cambio=%0d rech=%b, required all zero",
               out, credito, sirviendo, cambio_valid, cambio, moneda_rechazo);
    end
    rst = 1'b0;
    cyc();
    // selection and cancel are ignored while idle
    press(2'd0);
    cancel();
    n_cmp++;
    if (out !== 3'b000) begin
      n_err++;
      $display("FAIL idle_ignore: got out=%b, required 000", out);
    end
  endtask

  task automatic test_exact_price();
    int k;
    coin(2'd2);
    n_cmp++;
    if (out !== 3'b001 || credito !== 8'd5) begin
      n_err++;
      $display("FAIL coin5: got out=%b credito=%0d, required 001/5", out, credito);
    end
    coin(2'd2);
    n_cmp++;
    if (credito !== 8'd10) begin
      n_err++;
      $display("FAIL coin10: got credito=%0d, required 10", credito);
    end
    press(2'd2);
    n_cmp++;
    if (out !== 3'b010) begin
      n_err++;
      $display("FAIL exact_validar: got out=%b, required 010", out);
    end
    cyc();
    k = 0;
    while (sirviendo === 1'b1 && k < 20) begin
      if (out !== 3'b011) begin
        n_cmp++; n_err++;
        $display("FAIL exact_servir_state: got out=%b, required 011", out);
      end
      k++;
      cyc();
    end
    n_cmp++;
    if (k !== 4) begin
      n_err++;
      $display("FAIL exact_dispense_len: got %0d cycles, required 4", k);
    end
    n_cmp++;
    if (out !== 3'b000 || credito !== 8'd0) begin
      n_err++;
      $display("FAIL exact_end: got out=%b credito=%0d, required 000/0", out, credito);
    end
  endtask

  task automatic test_change();
    int k;
    coin(2'd3);
    coin(2'd1);
    n_cmp++;
    if (credito !== 8'd12) begin
      n_err++;
      $display("FAIL change_credit: got %0d, required 12", credito);
    end
    exp_cambio.push_back(8'd5);
    press(2'd1);
    cyc();
    k = 0;
    while (sirviendo === 1'b1 && k < 20) begin
      k++;
      cyc();
    end
    n_cmp++;
    if (k !== 4) begin
      n_err++;
      $display("FAIL change_dispense_len: got %0d cycles, required 4", k);
    end
    n_cmp++;
    if (out !== 3'b100 || cambio_valid !== 1'b1) begin
      n_err++;
      $display("FAIL change_state: got out=%b cv=%b, required 100/1", out, cambio_valid);
    end
    cyc();
    n_cmp++;
    if (out !== 3'b000 || credito !== 8'd0) begin
      n_err++;
      $display("FAIL change_end: got out=%b credito=%0d, required 000/0", out, credito);
    end
  endtask

  task automatic test_insufficient_cancel();
    coin(2'd2);
    press(2'd3);
    n_cmp++;
    if (out !== 3'b010) begin
      n_err++;
      $display("FAIL insuf_validar: got out=%b, required 010", out);
    end
    cyc();
    n_cmp++;
    if (out !== 3'b001 || credito !== 8'd5) begin
      n_err++;
      $display("FAIL insuf_back: got out=%b credito=%0d, required 001/5", out, credito);
    end
    exp_cambio.push_back(8'd5);
    cancel();
    n_cmp++;
    if (out !== 3'b101) begin
      n_err++;
      $display("FAIL cancel_state: got out=%b, required 101", out);
    end
    cyc();
    n_cmp++;
    if (out !== 3'b000 || credito !== 8'd0) begin
      n_err++;
      $display("FAIL cancel_end: got out=%b credito=%0d, required 000/0", out, credito);
    end
  endtask

  task automatic test_no_supply();
    hc = 4'b1011;
    coin(2'd3);
    exp_cambio.push_back(8'd10);
    press(2'd2);
    cyc();
    n_cmp++;
    if (out !== 3'b101 || cambio_valid !== 1'b1) begin
      n_err++;
      $display("FAIL nosupply_state: got out=%b cv=%b, required 101/1", out, cambio_valid);
    end
    cyc();
    n_cmp++;
    if (out !== 3'b000) begin
      n_err++;
      $display("FAIL nosupply_end: got out=%b, required 000", out);
    end
    hc = 4'b1111;
  endtask

  task automatic test_priority();
    coin(2'd2);
    hm = 1'b1; tm = 2'd0; bp = 1'b1; bb = 2'd0;
    cyc();
    hm = 1'b0; bp = 1'b0;
    n_cmp++;
    if (out !== 3'b001 || credito !== 8'd6) begin
      n_err++;
      $display("FAIL prio_coin_over_bp: got out=%b credito=%0d, required 001/6", out, credito);
    end
    exp_cambio.push_back(8'd6);
    cancel();
    cyc();
  endtask

  task automatic test_back_to_back();
    int k;
    coin(2'd2);
    press(2'd0);
    cyc();
    k = 0;
    while (sirviendo === 1'b1 && k < 20) begin
      k++;
      if (k == 1) begin
        // coin and water loss while dispensing
        hm = 1'b1; tm = 2'd0; ha = 1'b0;
        exp_rech.push_back(8'd5);
      end
      cyc();
      hm = 1'b0;
    end
    ha = 1'b1;
    n_cmp++;
    if (k !== 4 || out !== 3'b000 || credito !== 8'd0) begin
      n_err++;
      $display("FAIL servir_no_abort: got %0d cycles out=%b credito=%0d, required 4/000/0", k, out, credito);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 25; i++) coin(2'd3);
    n_cmp++;
    if (credito !== 8'd250) begin
      n_err++;
      $display("FAIL ovf_build: got %0d, required 250", credito);
    end
    exp_rech.push_back(8'd250);
    coin(2'd3);
    n_cmp++;
    if (credito !== 8'd250 || out !== 3'b001) begin
      n_err++;
      $display("FAIL ovf_reject: got credito=%0d out=%b, required 250/001", credito, out);
    end
    exp_rech.push_back(8'd250);
    exp_cambio.push_back(8'd250);
    hm = 1'b1; tm = 2'd3; cancelar = 1'b1;
    cyc();
    hm = 1'b0; cancelar = 1'b0;
    n_cmp++;
    if (out !== 3'b101) begin
      n_err++;
      $display("FAIL ovf_cancel_state: got out=%b, required 101", out);
    end
    cyc();
  endtask

  task automatic test_reset_servir();
    coin(2'd3);
    press(2'd0);
    cyc();
    cyc();
    n_cmp++;
    if (sirviendo !== 1'b1 || out !== 3'b011) begin
      n_err++;
      $display("FAIL rst_pre: got sirv=%b out=%b, required 1/011", sirviendo, out);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out, credito, sirviendo, cambio_valid, cambio, moneda_rechazo} !== 22'd0) begin
      n_err++;
      $display("FAIL rst_servir: got out=%b credito=%0d sirv=%b cv=%b cambio=%0d rech=%b, required all zero",
               out, credito, sirviendo, cambio_valid, cambio, moneda_rechazo);
    end
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    n_cmp++;
    if (out !== 3'b000 || sirviendo !== 1'b0) begin
      n_err++;
      $display("FAIL rst_after: got out=%b sirv=%b, required 000/0", out, sirviendo);
    end
  endtask

  initial begin
    test_reset();
    test_exact_price();
    test_change();
    test_insufficient_cancel();
    test_no_supply();
    test_priority();
    test_back_to_back();
    test_overflow();
    test_reset_servir();
    cyc();
    n_cmp++;
    if (exp_cambio.size() !== 0 || exp_rech.size() !== 0) begin
      n_err++;
      $display("FAIL pending_pulses: got %0d change / %0d reject still outstanding, required 0/0",
               exp_cambio.size(), exp_rech.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
